// File: rtl/sc_fifo_thr.sv
// Single-clock FIFO with almost-full/almost-empty thresholds, show-ahead or registered read, flush and error flags.
// Define SC_FIFO_THR_STICKY_ERR_EN to make overflow_o/underflow_o sticky until rst_i or flush_i.
module sc_fifo_thr #(
    parameter int DATA_WIDTH   = 8,
    parameter int WORDS_AMOUNT = 8,
    parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
    parameter int SHOW_AHEAD   = 1,
    parameter int AF_THRESHOLD = WORDS_AMOUNT - 2,
    parameter int AE_THRESHOLD = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic [ADDR_WIDTH:0]   used_words_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [ADDR_WIDTH:0]   FULL_LVL = (ADDR_WIDTH+1)'(WORDS_AMOUNT);
    localparam logic [ADDR_WIDTH:0]   AF_LVL   = (ADDR_WIDTH+1)'(AF_THRESHOLD);
    localparam logic [ADDR_WIDTH:0]   AE_LVL   = (ADDR_WIDTH+1)'(AE_THRESHOLD);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [WORDS_AMOUNT];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   used_words, used_nxt;
    logic                  wr_acc, rd_acc, ovf_req, unf_req, ovf_nxt, unf_nxt;

    assign used_words_o = used_words;

    // Flush swallows both requests, including their error pulses.
    assign wr_acc  = !flush_i && wr_i && !full_o;
    assign rd_acc  = !flush_i && rd_i && !empty_o;
    assign ovf_req = !flush_i && wr_i && full_o;
    assign unf_req = !flush_i && rd_i && empty_o;

    always_comb begin
        used_nxt = used_words;
        if (flush_i)
            used_nxt = '0;
        else if (wr_acc && !rd_acc)
            used_nxt = used_words + CNT_ONE;
        else if (rd_acc && !wr_acc)
            used_nxt = used_words - CNT_ONE;
    end

`ifdef SC_FIFO_THR_STICKY_ERR_EN
    assign ovf_nxt = overflow_o | ovf_req;
    assign unf_nxt = underflow_o | unf_req;
`else
    assign ovf_nxt = ovf_req;
    assign unf_nxt = unf_req;
`endif

    always_ff @(posedge clk_i) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            used_words     <= '0;
            full_o         <= 1'b0;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            if (flush_i)
                wr_ptr <= '0;
            else if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            used_words     <= used_nxt;
            full_o         <= (used_nxt == FULL_LVL);
            almost_full_o  <= (used_nxt >= AF_LVL);
            almost_empty_o <= (used_nxt <= AE_LVL);
            overflow_o     <= flush_i ? 1'b0 : ovf_nxt;
            underflow_o    <= flush_i ? 1'b0 : unf_nxt;
        end
    end

    if (SHOW_AHEAD != 0) begin : g_show_ahead
        // used_words counts the word held in the output register; ram_cnt is what is still in RAM.
        logic                out_vld;
        logic [ADDR_WIDTH:0] ram_cnt;

        assign ram_cnt    = used_words - {{ADDR_WIDTH{1'b0}}, out_vld};
        assign empty_o    = !out_vld;
        assign rd_valid_o = out_vld;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                out_vld   <= 1'b0;
                rd_ptr    <= '0;
                rd_data_o <= '0;
            end else if (flush_i) begin
                out_vld   <= 1'b0;
                rd_ptr    <= '0;
                rd_data_o <= '0;
            end else if (rd_acc && wr_acc && ram_cnt == '0) begin
                // Read+write at fill 1: forward the incoming word so the stream never bubbles.
                rd_data_o <= wr_data_i;
                rd_ptr    <= rd_ptr + PTR_ONE;
            end else if (ram_cnt != '0 && (!out_vld || rd_acc)) begin
                rd_data_o <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_ONE;
                out_vld   <= 1'b1;
            end else if (rd_acc) begin
                out_vld <= 1'b0;
            end
        end
    end else begin : g_normal
        logic empty_r, vld_r;

        assign empty_o    = empty_r;
        assign rd_valid_o = vld_r;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                empty_r   <= 1'b1;
                vld_r     <= 1'b0;
                rd_ptr    <= '0;
                rd_data_o <= '0;
            end else if (flush_i) begin
                empty_r   <= 1'b1;
                vld_r     <= 1'b0;
                rd_ptr    <= '0;
                rd_data_o <= '0;
            end else begin
                empty_r <= (used_nxt == '0);
                vld_r   <= rd_acc;
                if (rd_acc) begin
                    rd_data_o <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

endmodule
